// File: rtl/silife_max7219_pkg.sv
// Shared definitions for the MAX7219 receiver slice.
//   - Register addresses as seen in bits [11:8] of a 16-bit frame
//   - Code-B seven-segment patterns, bit order {A,B,C,D,E,F,G} = D6..D0
//   - Receiver FSM state type
package silife_max7219_pkg;

  localparam logic [3:0] REG_NOOP       = 4'h0;
  localparam logic [3:0] REG_DIGIT0     = 4'h1;
  localparam logic [3:0] REG_DIGIT7     = 4'h8;
  localparam logic [3:0] REG_DECODE     = 4'h9;
  localparam logic [3:0] REG_INTENSITY  = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
  localparam logic [3:0] REG_TEST       = 4'hF;

  localparam int unsigned FRAME_BITS = 16;
  localparam logic [4:0]  FRAME_FULL = 5'd16;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_DASH  = 7'h01;
  localparam logic [6:0] SEG_E     = 7'h4F;
  localparam logic [6:0] SEG_H     = 7'h37;
  localparam logic [6:0] SEG_L     = 7'h0E;
  localparam logic [6:0] SEG_P     = 7'h67;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } sink_state_t;

endpackage

// File: rtl/silife_max7219_codeb.sv
// Combinational MAX7219 code-B decoder.
//   i_digit [7:0] : raw digit register; [3:0] selects the glyph, [7] is the
//                   decimal point, [6:4] are ignored
//   o_seg   [7:0] : {DP, A, B, C, D, E, F, G}
module silife_max7219_codeb
  import silife_max7219_pkg::*;
(
  input  logic [7:0] i_digit,
  output logic [7:0] o_seg
);

  logic [6:0] seg;

  always_comb begin
    seg = SEG_BLANK;
    case (i_digit[3:0])
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_DASH;
      4'hB: seg = SEG_E;
      4'hC: seg = SEG_H;
      4'hD: seg = SEG_L;
      4'hE: seg = SEG_P;
      default: seg = SEG_BLANK;
    endcase
  end

  assign o_seg = {i_digit[7], seg};

endmodule

// File: rtl/silife_max7219_sink.sv
// MAX7219-compatible SPI receiver (slave end of the matrix-display link).
//   clk, reset        : system clock, asynchronous active-low reset
//   i_cs/i_sck/i_mosi : LOAD, serial clock, serial data (MSB first)
//   o_dout            : chain output, shift-register bit 15 on SCK falling edge
//   i_row_addr        : digit row to read; o_row_data follows one cycle later
//   o_intensity, o_scan_limit, o_enabled, o_test : control registers
//   o_load / o_word   : accepted-frame strobe and the frame itself
//   o_frame_err       : strobe when LOAD arrives with fewer than 16 bits
module silife_max7219_sink
  import silife_max7219_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_cs,
  input  logic        i_sck,
  input  logic        i_mosi,
  output logic        o_dout,
  input  logic [2:0]  i_row_addr,
  output logic [7:0]  o_row_data,
  output logic [3:0]  o_intensity,
  output logic [2:0]  o_scan_limit,
  output logic        o_enabled,
  output logic        o_test,
  output logic        o_load,
  output logic [15:0] o_word,
  output logic        o_frame_err
);

  logic cs_s, sck_s, mosi_s;

  // All three inputs see the same depth so SCK/MOSI/CS ordering is preserved.
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign cs_s   = i_cs;
      assign sck_s  = i_sck;
      assign mosi_s = i_mosi;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] cs_ff, sck_ff, mosi_ff;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cs_ff   <= '1;
          sck_ff  <= '0;
          mosi_ff <= '0;
        end else begin
          cs_ff[0]   <= i_cs;
          sck_ff[0]  <= i_sck;
          mosi_ff[0] <= i_mosi;
          for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            cs_ff[i]   <= cs_ff[i-1];
            sck_ff[i]  <= sck_ff[i-1];
            mosi_ff[i] <= mosi_ff[i-1];
          end
        end
      end
      assign cs_s   = cs_ff[SYNC_STAGES-1];
      assign sck_s  = sck_ff[SYNC_STAGES-1];
      assign mosi_s = mosi_ff[SYNC_STAGES-1];
    end
  endgenerate

  logic cs_d, sck_d;
  logic cs_rise, cs_fall, sck_rise, sck_fall;

  assign cs_rise  = cs_s  & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  sink_state_t state, state_nx;
  logic [15:0] shreg, shreg_nx;
  logic [4:0]  bit_cnt, cnt_nx;
  logic        dout_nx, do_latch, do_err;

  // A same-cycle SCK rise is folded into shreg_nx/cnt_nx before the LOAD
  // decision, so the last bit of a frame still counts.
  always_comb begin
    state_nx = state;
    shreg_nx = shreg;
    cnt_nx   = bit_cnt;
    dout_nx  = o_dout;
    do_latch = 1'b0;
    do_err   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cs_fall) begin
          state_nx = ST_SHIFT;
          cnt_nx   = '0;
        end
      end
      ST_SHIFT: begin
        if (sck_rise) begin
          shreg_nx = {shreg[FRAME_BITS-2:0], mosi_s};
          if (bit_cnt != FRAME_FULL) cnt_nx = bit_cnt + 5'd1;
        end
        if (sck_fall) dout_nx = shreg[FRAME_BITS-1];
        if (cs_rise) begin
          state_nx = ST_IDLE;
          if (cnt_nx == FRAME_FULL) do_latch = 1'b1;
          else                      do_err   = 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  logic [7:0] digits [8];
  logic [7:0] decode_reg;
  logic [3:0] latch_addr;

  assign latch_addr = shreg_nx[11:8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cs_d         <= 1'b1;
      sck_d        <= 1'b0;
      shreg        <= '0;
      bit_cnt      <= '0;
      o_dout       <= 1'b0;
      o_load       <= 1'b0;
      o_frame_err  <= 1'b0;
      o_word       <= '0;
      digits       <= '{default: '0};
      decode_reg   <= '0;
      o_intensity  <= '0;
      o_scan_limit <= '0;
      o_enabled    <= 1'b0;
      o_test       <= 1'b0;
    end else begin
      cs_d        <= cs_s;
      sck_d       <= sck_s;
      shreg       <= shreg_nx;
      bit_cnt     <= cnt_nx;
      o_dout      <= dout_nx;
      o_load      <= do_latch;
      o_frame_err <= do_err;
      if (do_latch) begin
        o_word <= shreg_nx;
        if (latch_addr >= REG_DIGIT0 && latch_addr <= REG_DIGIT7)
          digits[3'(latch_addr - REG_DIGIT0)] <= shreg_nx[7:0];
        case (latch_addr)
          REG_DECODE:     decode_reg   <= shreg_nx[7:0];
          REG_INTENSITY:  o_intensity  <= shreg_nx[3:0];
          REG_SCAN_LIMIT: o_scan_limit <= shreg_nx[2:0];
          REG_SHUTDOWN:   o_enabled    <= shreg_nx[0];
          REG_TEST:       o_test       <= shreg_nx[0];
          default: ;
        endcase
      end
    end
  end

  logic [7:0] row_digit, row_codeb, row_nx;

  assign row_digit = digits[i_row_addr];

  silife_max7219_codeb u_codeb (
    .i_digit (row_digit),
    .o_seg   (row_codeb)
  );

  always_comb begin
    row_nx = '0;
    if (o_test)                         row_nx = '1;
    else if (!o_enabled)                row_nx = '0;
    else if (i_row_addr > o_scan_limit) row_nx = '0;
    else if (decode_reg[i_row_addr])    row_nx = row_codeb;
    else                                row_nx = row_digit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) o_row_data <= '0;
    else        o_row_data <= row_nx;
  end

endmodule

// File: tb/tb_silife_max7219_sink.sv
module tb_silife_max7219_sink;

  localparam int H = 6;  // clk cycles per SCK half period

  logic clk = 1'b0;
  logic reset, cs, sck, mosi;
  logic [2:0] row_addr;

  logic        dout_a, dout_b, dout_c;
  logic [7:0]  row_a, row_b, row_c;
  logic [3:0]  int_a, int_b, int_c;
  logic [2:0]  scan_a, scan_b, scan_c;
  logic        en_a, en_b, en_c, test_a, test_b, test_c;
  logic        load_a, load_b, load_c, err_a, err_b, err_c;
  logic [15:0] word_a, word_b, word_c;

  int tests = 0;
  int fails = 0;
  int load_cnt_a = 0, load_cnt_c = 0, err_cnt_a = 0;
  int l0, e0;
  logic [7:0] rd;

  always #5 clk = ~clk;

  silife_max7219_sink #(.SYNC_STAGES(2)) u_a (
    .clk(clk), .reset(reset), .i_cs(cs), .i_sck(sck), .i_mosi(mosi), .o_dout(dout_a),
    .i_row_addr(row_addr), .o_row_data(row_a), .o_intensity(int_a), .o_scan_limit(scan_a),
    .o_enabled(en_a), .o_test(test_a), .o_load(load_a), .o_word(word_a), .o_frame_err(err_a));

  silife_max7219_sink #(.SYNC_STAGES(2)) u_b (
    .clk(clk), .reset(reset), .i_cs(cs), .i_sck(sck), .i_mosi(dout_a), .o_dout(dout_b),
    .i_row_addr(row_addr), .o_row_data(row_b), .o_intensity(int_b), .o_scan_limit(scan_b),
    .o_enabled(en_b), .o_test(test_b), .o_load(load_b), .o_word(word_b), .o_frame_err(err_b));

  silife_max7219_sink #(.SYNC_STAGES(0)) u_c (
    .clk(clk), .reset(reset), .i_cs(cs), .i_sck(sck), .i_mosi(mosi), .o_dout(dout_c),
    .i_row_addr(row_addr), .o_row_data(row_c), .o_intensity(int_c), .o_scan_limit(scan_c),
    .o_enabled(en_c), .o_test(test_c), .o_load(load_c), .o_word(word_c), .o_frame_err(err_c));

  always @(posedge clk) begin
    if (load_a) load_cnt_a <= load_cnt_a + 1;
    if (load_c) load_cnt_c <= load_cnt_c + 1;
    if (err_a)  err_cnt_a  <= err_cnt_a + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] data, input int n);
    cs = 1'b0;
    wait_clks(H);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = data[i];
      wait_clks(H);
      sck = 1'b1;
      wait_clks(H);
      sck = 1'b0;
    end
    wait_clks(H);
    cs = 1'b1;
    wait_clks(H);
  endtask

  task automatic read_row(input logic [2:0] r, output logic [7:0] d);
    @(negedge clk);
    row_addr = r;
    @(posedge clk);
    #1 d = row_a;
  endtask

  initial begin
    reset = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0; row_addr = '0;
    wait_clks(4);
    check("rst_intensity", 16'(int_a), 16'h0);
    check("rst_enabled",   16'(en_a),  16'h0);
    check("rst_test",      16'(test_a), 16'h0);
    check("rst_word",      word_a,     16'h0000);
    check("rst_dout",      16'(dout_a), 16'h0);
    check("rst_row",       16'(row_a),  16'h00);
    reset = 1'b1;
    wait_clks(4);

    send_frame(32'h0A05, 16);
    send_frame(32'h0C01, 16);
    check("load_pulses",   16'(load_cnt_a), 16'd2);
    check("intensity",     16'(int_a), 16'h5);
    check("enabled",       16'(en_a),  16'h1);
    check("word_0c01",     word_a,     16'h0C01);
    check("c_intensity",   16'(int_c), 16'h5);
    check("c_load_pulses", 16'(load_cnt_c), 16'd2);

    send_frame(32'h0381, 16);
    send_frame(32'h0B07, 16);
    check("scan_limit", 16'(scan_a), 16'h7);
    read_row(3'd2, rd); check("row2_raw", 16'(rd), 16'h81);
    read_row(3'd0, rd); check("row0_zero", 16'(rd), 16'h00);
    read_row(3'd1, rd); check("row1_zero", 16'(rd), 16'h00);
    send_frame(32'h0F01, 16);
    read_row(3'd0, rd); check("test_row0", 16'(rd), 16'hFF);
    read_row(3'd7, rd); check("test_row7", 16'(rd), 16'hFF);
    send_frame(32'h0F00, 16);

    send_frame(32'h0901, 16);
    send_frame(32'h0185, 16);
    read_row(3'd0, rd); check("codeb_5_dp", 16'(rd), 16'hDB);
    read_row(3'd2, rd); check("row2_still_raw", 16'(rd), 16'h81);
    send_frame(32'h0B01, 16);
    read_row(3'd2, rd); check("row2_beyond_scan", 16'(rd), 16'h00);
    read_row(3'd1, rd); check("row1_in_scan", 16'(rd), 16'h00);
    send_frame(32'h0B07, 16);

    l0 = load_cnt_a; e0 = err_cnt_a;
    send_frame(32'h0A0F, 12);
    check("short_err",      16'(err_cnt_a - e0),  16'd1);
    check("short_no_load",  16'(load_cnt_a - l0), 16'd0);
    check("short_int_kept", 16'(int_a), 16'h5);
    check("short_word_kept", word_a,    16'h0B07);

    send_frame(32'h0155_02AA, 32);
    check("chain_word_a", word_a, 16'h02AA);
    check("chain_word_b", word_b, 16'h0155);
    check("chain_word_c", word_c, 16'h02AA);
    read_row(3'd1, rd); check("digit1_raw", 16'(rd), 16'hAA);
    send_frame(32'h0903, 16);
    read_row(3'd1, rd); check("codeb_dash_dp", 16'(rd), 16'h81);

    cs = 1'b0;
    wait_clks(H);
    for (int i = 0; i < 6; i++) begin
      mosi = i[0];
      wait_clks(H); sck = 1'b1;
      wait_clks(H); sck = 1'b0;
    end
    reset = 1'b0;
    wait_clks(2);
    cs = 1'b1;
    check("midrst_intensity", 16'(int_a), 16'h0);
    check("midrst_enabled",   16'(en_a),  16'h0);
    check("midrst_word",      word_a,     16'h0000);
    reset = 1'b1;
    wait_clks(4);
    send_frame(32'h0A03, 16);
    check("post_rst_intensity", 16'(int_a), 16'h3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
